// File: rtl/mem_bridge.sv
// mem_bridge: converts core load/store requests (byte/half/word at any byte
// address) into single word-aligned bus transactions with byte strobes, then
// returns a one-cycle completion pulse with sign/zero-extended load data.
// Misaligned/illegal accesses and bus timeouts complete with core_err=1.
//
// Ports
//   clk, rst           clock (rising edge), async active-high reset
//   core_valid/we/size/unsigned/addr/wdata   request from core, held until core_ready
//   core_rdata/ready/err                     one-cycle completion back to core
//   bus_valid/we/addr/wstrb/wdata            word-aligned bus request
//   bus_ready/rdata                          bus completion and read word
module mem_bridge #(
  parameter int TIMEOUT_CYCLES = 255,  // 0 disables the timeout
  parameter int TIMEOUT_W      = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        core_valid,
  input  logic        core_we,
  input  logic [1:0]  core_size,
  input  logic        core_unsigned,
  input  logic [31:0] core_addr,
  input  logic [31:0] core_wdata,
  output logic [31:0] core_rdata,
  output logic        core_ready,
  output logic        core_err,
  output logic        bus_valid,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_wstrb,
  output logic [31:0] bus_wdata,
  input  logic        bus_ready,
  input  logic [31:0] bus_rdata
);

  typedef enum logic [1:0] {IDLE, REQ, RESP, ERR} state_t;

  // one extra bit so the compare against the limit never wraps
  localparam logic [TIMEOUT_W:0] LIMIT = (TIMEOUT_W+1)'(TIMEOUT_CYCLES);

  state_t               state, state_nx;
  logic [TIMEOUT_W-1:0] cnt;
  logic [TIMEOUT_W:0]   cnt_next;
  logic                 timeout_hit;
  logic                 misaligned;
  logic [1:0]           lane;
  logic [1:0]           size;
  logic                 uns;

  // Shift the addressed lane down, then truncate and extend to the access size.
  function automatic logic [31:0] extend(input logic [31:0] word, input logic [1:0] ln,
                                         input logic [1:0] sz, input logic zx);
    logic [31:0] s;
    s = word >> {ln, 3'b000};
    case (sz)
      2'd0:    extend = zx ? {24'b0, s[7:0]}  : {{24{s[7]}}, s[7:0]};
      2'd1:    extend = zx ? {16'b0, s[15:0]} : {{16{s[15]}}, s[15:0]};
      default: extend = s;
    endcase
  endfunction

  always_comb begin
    misaligned = (core_size == 2'd3) ||
                 (core_size == 2'd1 && core_addr[0]) ||
                 (core_size == 2'd2 && core_addr[1:0] != 2'b00);
  end

  always_comb begin
    cnt_next    = {1'b0, cnt} + {{TIMEOUT_W{1'b0}}, 1'b1};
    timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt_next == LIMIT);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (core_valid) state_nx = misaligned ? ERR : REQ;
      // a ready arriving on the limit cycle takes priority over the timeout
      REQ:     if (bus_ready) state_nx = RESP;
               else if (timeout_hit) state_nx = ERR;
      RESP:    state_nx = IDLE;
      ERR:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // All outputs are registered: the completion pulse is loaded on the edge
  // that enters RESP/ERR so it lines up with that state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      core_rdata <= '0;
      core_ready <= 1'b0;
      core_err   <= 1'b0;
      bus_valid  <= 1'b0;
      bus_we     <= 1'b0;
      bus_addr   <= '0;
      bus_wstrb  <= '0;
      bus_wdata  <= '0;
      cnt        <= '0;
      lane       <= '0;
      size       <= '0;
      uns        <= 1'b0;
    end else begin
      core_rdata <= '0;
      core_ready <= 1'b0;
      core_err   <= 1'b0;
      bus_valid  <= (state_nx == REQ);
      case (state)
        IDLE: if (core_valid) begin
          if (misaligned) begin
            core_ready <= 1'b1;
            core_err   <= 1'b1;
          end else begin
            bus_we   <= core_we;
            bus_addr <= {core_addr[31:2], 2'b00};
            lane     <= core_addr[1:0];
            size     <= core_size;
            uns      <= core_unsigned;
            cnt      <= '0;
            case (core_size)
              2'd0: begin
                bus_wdata <= {4{core_wdata[7:0]}};
                bus_wstrb <= core_we ? (4'b0001 << core_addr[1:0]) : 4'b0000;
              end
              2'd1: begin
                bus_wdata <= {2{core_wdata[15:0]}};
                bus_wstrb <= core_we ? (4'b0011 << core_addr[1:0]) : 4'b0000;
              end
              default: begin
                bus_wdata <= core_wdata;
                bus_wstrb <= core_we ? 4'b1111 : 4'b0000;
              end
            endcase
          end
        end
        REQ: begin
          if (bus_ready) begin
            core_ready <= 1'b1;
            core_rdata <= bus_we ? 32'b0 : extend(bus_rdata, lane, size, uns);
          end else begin
            cnt <= cnt_next[TIMEOUT_W-1:0];
            if (timeout_hit) begin
              core_ready <= 1'b1;
              core_err   <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_bridge.sv
// Directed bench for mem_bridge (TIMEOUT_CYCLES=4). A reference model derives
// expected responses and bus fields from each request; one negedge process
// compares DUT outputs to it every cycle, and the driver checks latency,
// bus_valid duration and a few literal values.
module tb_mem_bridge;
  localparam int TO = 4;

  logic        clk = 1'b0, rst = 1'b1;
  logic        core_valid, core_we, core_unsigned;
  logic [1:0]  core_size;
  logic [31:0] core_addr, core_wdata, core_rdata;
  logic        core_ready, core_err;
  logic        bus_valid, bus_we, bus_ready;
  logic [31:0] bus_addr, bus_wdata, bus_rdata;
  logic [3:0]  bus_wstrb;

  always #5 clk = ~clk;

  mem_bridge #(.TIMEOUT_CYCLES(TO), .TIMEOUT_W(8)) dut (
    .clk(clk), .rst(rst),
    .core_valid(core_valid), .core_we(core_we), .core_size(core_size),
    .core_unsigned(core_unsigned), .core_addr(core_addr), .core_wdata(core_wdata),
    .core_rdata(core_rdata), .core_ready(core_ready), .core_err(core_err),
    .bus_valid(bus_valid), .bus_we(bus_we), .bus_addr(bus_addr),
    .bus_wstrb(bus_wstrb), .bus_wdata(bus_wdata),
    .bus_ready(bus_ready), .bus_rdata(bus_rdata)
  );

  typedef struct { logic [31:0] rdata; logic err; } resp_t;
  resp_t       exp_q[$];
  resp_t       cur;
  logic        eb_en, eb_we;
  logic [31:0] eb_addr, eb_wdata;
  logic [3:0]  eb_wstrb;
  logic [31:0] last_addr, last_wdata, last_rdata;
  logic [3:0]  last_strb;
  int n_chk = 0, n_fail = 0, cyc = 0;
  int r1, r2;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %h required %h", name, act, exp);
    end
  endtask

  // ---- reference model ----
  function automatic bit m_bad(input logic [1:0] size, input logic [31:0] addr);
    return (size == 2'd3) || ((addr % (32'd1 << size)) != 0);
  endfunction

  function automatic logic [31:0] m_load(input logic [31:0] w, input logic [1:0] lane,
                                         input logic [1:0] size, input logic uns);
    longint m, v;
    m = longint'(1) << (8 * (1 << size));
    v = (longint'(w) >> (8 * lane)) % m;
    if (!uns && v >= m / 2) v = v - m;
    return v[31:0];
  endfunction

  function automatic logic [31:0] m_wdata(input logic [31:0] d, input logic [1:0] size);
    logic [31:0] r;
    int nb;
    nb = 1 << size;
    for (int i = 0; i < 4; i++) r[8*i +: 8] = d[8*(i % nb) +: 8];
    return r;
  endfunction

  function automatic logic [3:0] m_strb(input logic [1:0] size, input logic [1:0] lane);
    int nb;
    nb = 1 << size;
    return 4'(((1 << nb) - 1) << lane);
  endfunction

  // ---- compare process ----
  always @(negedge clk) begin
    if (!rst) begin
      if (core_ready) begin
        if (exp_q.size() == 0) chk("unexpected_ready", 32'd1, 32'd0);
        else begin
          cur = exp_q.pop_front();
          chk("core_rdata", core_rdata, cur.rdata);
          chk("core_err", 32'(core_err), 32'(cur.err));
        end
      end else begin
        chk("quiet_rdata", core_rdata, 32'd0);
        chk("quiet_err", 32'(core_err), 32'd0);
      end
      if (bus_valid) begin
        if (!eb_en) chk("unexpected_bus_valid", 32'd1, 32'd0);
        else begin
          chk("bus_addr", bus_addr, eb_addr);
          chk("bus_we", 32'(bus_we), 32'(eb_we));
          chk("bus_wstrb", 32'(bus_wstrb), 32'(eb_wstrb));
          if (eb_we) chk("bus_wdata", bus_wdata, eb_wdata);
        end
      end
    end
  end

  // ---- driver ----
  task automatic setup(input logic we, input logic [1:0] size, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wd,
                       input logic [31:0] rdw, input bit tmo);
    resp_t r;
    bit bad;
    bad     = m_bad(size, addr);
    r.err   = bad || tmo;
    r.rdata = (r.err || we) ? 32'd0 : m_load(rdw, addr[1:0], size, uns);
    exp_q.push_back(r);
    eb_en    = !bad;
    eb_we    = we;
    eb_addr  = {addr[31:2], 2'b00};
    eb_wstrb = we ? m_strb(size, addr[1:0]) : 4'b0000;
    eb_wdata = m_wdata(wd, size);
    core_valid = 1'b1; core_we = we; core_size = size; core_unsigned = uns;
    core_addr = addr; core_wdata = wd;
  endtask

  task automatic run(input int waits, input logic [31:0] rdw, input int exp_lat,
                     input int exp_bv, output int rcyc);
    int vc, k;
    bit got;
    vc = 0; k = 0; got = 0; rcyc = 0;
    while (!got && k < 40) begin
      @(negedge clk);
      if (bus_valid) begin
        bus_ready  = (vc == waits);
        bus_rdata  = (vc == waits) ? rdw : 32'hDEAD_BEEF;
        last_addr  = bus_addr; last_strb = bus_wstrb; last_wdata = bus_wdata;
        vc++;
      end else begin
        bus_ready = 1'b0; bus_rdata = '0;
      end
      if (core_ready) begin
        got = 1; rcyc = cyc; last_rdata = core_rdata;
        chk("latency", k, exp_lat);
      end
      @(posedge clk); #1;
      k++;
    end
    if (!got) chk("ready_wait_expired", 32'd0, 32'd1);
    chk("bus_valid_cycles", vc, exp_bv);
    bus_ready = 1'b0;
  endtask

  task automatic go(input logic we, input logic [1:0] size, input logic uns,
                    input logic [31:0] addr, input logic [31:0] wd, input logic [31:0] rdw,
                    input int waits, input bit tmo, input int lat, input int bv,
                    output int rcyc);
    setup(we, size, uns, addr, wd, rdw, tmo);
    run(waits, rdw, lat, bv, rcyc);
  endtask

  task automatic idle();
    core_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    core_valid = 0; core_we = 0; core_size = 0; core_unsigned = 0;
    core_addr = 0; core_wdata = 0; bus_ready = 0; bus_rdata = 0;
    eb_en = 0; eb_we = 0; eb_addr = 0; eb_wdata = 0; eb_wstrb = 0;
    repeat (2) @(posedge clk); #1;
    chk("rst_bus_valid", 32'(bus_valid), 32'd0);
    chk("rst_core_ready", 32'(core_ready), 32'd0);
    chk("rst_core_rdata", core_rdata, 32'd0);
    chk("rst_bus_addr", bus_addr, 32'd0);
    chk("rst_bus_wstrb", 32'(bus_wstrb), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // signed byte load, immediate bus ready
    go(0, 2'd0, 0, 32'h103, 0, 32'h80FF_1234, 0, 0, 2, 1, r1);
    chk("lb_rdata_lit", last_rdata, 32'hFFFF_FF80);
    chk("lb_addr_lit", last_addr, 32'h100);
    chk("lb_strb_lit", 32'(last_strb), 32'd0);
    idle();
    // half store with 3 wait cycles
    go(1, 2'd1, 0, 32'h2002, 32'h0000_ABCD, 0, 3, 0, 5, 4, r1);
    chk("sh_strb_lit", 32'(last_strb), 32'hC);
    chk("sh_wdata_lit", last_wdata, 32'hABCD_ABCD);
    idle();
    // misaligned / illegal
    go(0, 2'd2, 0, 32'h6, 0, 0, 0, 0, 1, 0, r1);  idle();
    go(0, 2'd3, 0, 32'h40, 0, 0, 0, 0, 1, 0, r1); idle();
    go(1, 2'd1, 0, 32'h1, 32'h55, 0, 0, 0, 1, 0, r1); idle();
    // timeout, then ready on the limit cycle
    go(0, 2'd2, 0, 32'h40, 0, 32'h1, 99, 1, TO + 1, TO, r1); idle();
    go(0, 2'd2, 0, 32'h44, 0, 32'h1234_5678, TO - 1, 0, TO + 1, TO, r1);
    chk("lw_limit_rdata_lit", last_rdata, 32'h1234_5678);
    idle();
    // extension and lane variants
    go(0, 2'd0, 1, 32'h102, 0, 32'h80FF_1234, 0, 0, 2, 1, r1); idle();
    go(0, 2'd0, 0, 32'h102, 0, 32'h80FF_1234, 1, 0, 3, 2, r1); idle();
    go(0, 2'd1, 0, 32'h2, 0, 32'h80FF_1234, 0, 0, 2, 1, r1);
    chk("lh_rdata_lit", last_rdata, 32'hFFFF_80FF);
    idle();
    go(0, 2'd1, 1, 32'h2, 0, 32'h80FF_1234, 0, 0, 2, 1, r1); idle();
    go(1, 2'd0, 0, 32'h13, 32'h5A, 0, 0, 0, 2, 1, r1);
    chk("sb_strb_lit", 32'(last_strb), 32'h8);
    idle();
    go(1, 2'd2, 0, 32'h20, 32'hCAFE_F00D, 0, 2, 0, 4, 3, r1); idle();

    // reset while in REQ
    setup(0, 2'd2, 0, 32'h80, 0, 32'h1111_1111, 0);
    @(posedge clk); #1;
    chk("req_bus_valid", 32'(bus_valid), 32'd1);
    @(posedge clk); #2;
    rst = 1'b1; #1;
    chk("rst_mid_bus_valid", 32'(bus_valid), 32'd0);
    chk("rst_mid_core_ready", 32'(core_ready), 32'd0);
    exp_q.delete();
    core_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (3) @(posedge clk); #1;
    go(0, 2'd2, 0, 32'h80, 0, 32'h1111_1111, 0, 0, 2, 1, r1); idle();

    // back-to-back with core_valid held high
    go(0, 2'd2, 0, 32'h10, 0, 32'hA5A5_0010, 0, 0, 2, 1, r1);
    go(0, 2'd2, 0, 32'h14, 0, 32'h5A5A_0014, 0, 0, 2, 1, r2);
    chk("b2b_spacing", r2 - r1, 32'd3);
    chk("b2b_rdata_lit", last_rdata, 32'h5A5A_0014);
    idle();
    repeat (3) @(posedge clk); #1;
    chk("queue_drained", exp_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
